// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared types and default sizing for the multi-port register file.
//   clr_state_e   - clear-sequencer state encoding (IDLE, CLEAR)
//   DEF_*         - default parameter values used by reg_file_mp and its sub-module
package reg_file_pkg;

  localparam int unsigned DEF_ADDRESS_WIDTH = 5;
  localparam int unsigned DEF_DATA_WIDTH    = 32;
  localparam int unsigned DEF_NUM_RD        = 2;
  localparam int unsigned DEF_NUM_WR        = 2;
  localparam int unsigned DEF_ZERO_REG      = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/reg_file_clear_ctrl.sv
// reg_file_clear_ctrl: sequences a full-array clear, one register per cycle.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset; (re)starts a clear from index 0
//   clr_req  - clear request, ignored while a clear is running
//   busy     - high exactly while in CLEAR
//   clr_idx  - index being zeroed this cycle
//   clr_we   - strobe to zero clr_idx this cycle
module reg_file_clear_ctrl
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  output logic                     busy,
  output logic [ADDRESS_WIDTH-1:0] clr_idx,
  output logic                     clr_we
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = '1;

  clr_state_e                 state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]   cnt_q, cnt_d;

  // State register; reset lands in CLEAR so the array is wiped after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: the terminal index is the only exit, so there is no second pass.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + ADDRESS_WIDTH'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy    = (state_q == CLEAR);
    clr_we  = (state_q == CLEAR);
    clr_idx = cnt_q;
  end

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with combinational reads and a
// sequenced full-array clear.
// Ports:
//   clk, rst  - clock (rising edge), synchronous active-high reset
//   clr_req   - start a clear of every register (one per cycle)
//   ra / rd   - NUM_RD packed read addresses / read data (combinational)
//   wa/wd/we  - NUM_WR packed write addresses / data / enables
//   busy      - high while the clear sequence runs; writes dropped, reads 0
// Build option: define REG_FILE_BYPASS_EN to forward same-cycle write data
// to matching read ports; otherwise reads return the pre-write contents.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned NUM_RD        = DEF_NUM_RD,
  parameter int unsigned NUM_WR        = DEF_NUM_WR,
  parameter int unsigned ZERO_REG      = DEF_ZERO_REG
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr_req,
  input  logic [NUM_RD*ADDRESS_WIDTH-1:0] ra,
  output logic [NUM_RD*DATA_WIDTH-1:0]    rd,
  input  logic [NUM_WR*ADDRESS_WIDTH-1:0] wa,
  input  logic [NUM_WR*DATA_WIDTH-1:0]    wd,
  input  logic [NUM_WR-1:0]               we,
  output logic                            busy
);

  localparam int unsigned NUM_REGS = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0]    mem_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]    mem_d [NUM_REGS];
  logic [ADDRESS_WIDTH-1:0] clr_idx;
  logic                     clr_we;

  reg_file_clear_ctrl #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_clear_ctrl (
    .clk     (clk),
    .rst     (rst),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_idx (clr_idx),
    .clr_we  (clr_we)
  );

  // Write merge: clear strobe owns the array while busy; otherwise later
  // ports override earlier ones on an address collision. rst blocks all writes.
  always_comb begin
    mem_d = mem_q;
    if (!rst) begin
      if (clr_we) begin
        mem_d[clr_idx] = '0;
      end else begin
        for (int unsigned j = 0; j < NUM_WR; j++) begin
          if (we[j] && !((ZERO_REG != 0) && (wa[j*ADDRESS_WIDTH +: ADDRESS_WIDTH] == '0))) begin
            mem_d[wa[j*ADDRESS_WIDTH +: ADDRESS_WIDTH]] = wd[j*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  // Storage; contents are defined by the clear sequence that follows reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Read mux; busy and the hardwired zero register both force 0.
  always_comb begin
    rd = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if (!busy && !((ZERO_REG != 0) && (ra[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] == '0))) begin
        rd[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[ra[i*ADDRESS_WIDTH +: ADDRESS_WIDTH]];
`ifdef REG_FILE_BYPASS_EN
        for (int unsigned j = 0; j < NUM_WR; j++) begin
          if (we[j] && (wa[j*ADDRESS_WIDTH +: ADDRESS_WIDTH] == ra[i*ADDRESS_WIDTH +: ADDRESS_WIDTH])) begin
            rd[i*DATA_WIDTH +: DATA_WIDTH] = wd[j*DATA_WIDTH +: DATA_WIDTH];
          end
        end
`endif
      end
    end
  end

endmodule
